// File: rtl/request_unit_multi.sv
`default_nettype none
// ============================================================================
//  Module   : request_unit_multi
//  Brief    : NCORES-wide data request unit with halt gating, busy status,
//             saturating stall watchdog and sticky timeout per channel.
//  Revision : 1.0 - initial release
// ============================================================================
module request_unit_multi #(
  parameter int NCORES  = 2,
  parameter int STALL_W = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NCORES-1:0]           ihit,
  input  logic [NCORES-1:0]           dhit,
  input  logic [NCORES-1:0]           dREN,
  input  logic [NCORES-1:0]           dWEN,
  input  logic [NCORES-1:0]           halt,
  output logic [NCORES-1:0]           dmemREN,
  output logic [NCORES-1:0]           dmemWEN,
  output logic [NCORES-1:0]           pcen,
  output logic [NCORES-1:0]           busy,
  output logic [NCORES-1:0]           timeout,
  output logic [NCORES*STALL_W-1:0]   stall_cnt
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  for (genvar i = 0; i < NCORES; i++) begin : g_ch
    state_t              r_state;
    logic                r_ren;
    logic                r_wen;
    logic                r_to;
    logic [STALL_W-1:0]  r_cnt;
    logic                w_req;
    logic                w_sat;
    logic [STALL_W-1:0]  w_cnt_nxt;

    // A dhit coinciding with the issue cycle is absorbed rather than opening a request.
    assign w_req     = ihit[i] & (dREN[i] | dWEN[i]) & ~halt[i] & ~dhit[i];
    assign w_sat     = &r_cnt;
    assign w_cnt_nxt = r_cnt + STALL_W'(1);

    always_ff @(posedge CLK) begin
      if (RST) begin
        r_state <= S_IDLE;
        r_ren   <= 1'b0;
        r_wen   <= 1'b0;
        r_to    <= 1'b0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_ren <= 1'b0;
            r_wen <= 1'b0;
            if (w_req) begin
              r_state <= S_REQ;
              r_wen   <= dWEN[i];
              r_ren   <= dREN[i] & ~dWEN[i];
              r_cnt   <= '0;
            end
          end
          S_REQ: begin
            if (dhit[i]) begin
              r_state <= S_IDLE;
              r_ren   <= 1'b0;
              r_wen   <= 1'b0;
            end else if (!w_sat) begin
              r_cnt <= w_cnt_nxt;
              if (&w_cnt_nxt) r_to <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
          end
        endcase
      end
    end

    assign dmemREN[i] = r_ren;
    assign dmemWEN[i] = r_wen;
    assign busy[i]    = (r_state == S_REQ);
    assign timeout[i] = r_to;
    assign stall_cnt[i*STALL_W +: STALL_W] = r_cnt;
    // Halt freezes the PC in both states; a completing request still needs ~halt to advance.
    assign pcen[i] = ~RST & ((r_state == S_IDLE) ? (ihit[i] & ~(dREN[i] | dWEN[i]) & ~halt[i])
                                                 : (dhit[i] & ~halt[i]));
  end

endmodule
`default_nettype wire
